sinalizador_led: RTL and testbench

- Output-side counterpart of the button conditioning blocks: converts single-cycle event pulses into human-visible LED blink bursts.
- Each accepted event produces N_PISCA blinks of fixed on/off duration.
- Events arriving during a burst are queued in a saturating pending counter and replayed back-to-back.
- Sits between game/control logic (pulse producers) and board LED pins.

---
 rtl/sinalizador_led_pkg.sv | 14 +
 rtl/sinalizador_led_contador_pendentes.sv | 46 ++++
 rtl/sinalizador_led.sv | 131 +++++++++++++
 tb/tb_sinalizador_led.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sinalizador_led_pkg.sv
// Shared definitions for the LED burst signaller: state encodings and
// the width helper used to size the phase timer and counters.
package pkg_sinalizador;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned largura(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sinalizador_led_contador_pendentes.sv
// Saturating up/down counter of queued events; pulses overflow when an
// increment is refused because the queue is already full.
module contador_pendentes #(
  parameter int unsigned MAX = 7,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  logic [W-1:0] count_q, count_d;
  logic         overflow_q, overflow_d;

  // Simultaneous inc and dec cancel out, so a full queue does not overflow.
  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (count_q == W'(MAX)) overflow_d = 1'b1;
      else                    count_d    = count_q + 1'b1;
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/sinalizador_led.sv
// Turns single-cycle event pulses into N_PISCA visible blinks each,
// queueing events that arrive mid-burst and replaying them back-to-back.
module sinalizador_led
  import pkg_sinalizador::*;
#(
  parameter int unsigned T_ON     = 25_000_000,
  parameter int unsigned T_OFF    = 25_000_000,
  parameter int unsigned N_PISCA  = 3,
  parameter int unsigned MAX_PEND = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          internal_reset,
  input  logic                          evento,
  input  logic                          cancela,
  output logic                          led,
  output logic                          ocupado,
  output logic [$clog2(MAX_PEND+1)-1:0] pendentes,
  output logic                          overflow
);

  localparam int unsigned TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int unsigned TW   = largura(TMAX);
  localparam int unsigned BW   = largura(N_PISCA + 1);
  localparam int unsigned PW   = $clog2(MAX_PEND + 1);

  localparam logic [TW-1:0] FIM_ON  = TW'(T_ON - 1);
  localparam logic [TW-1:0] FIM_OFF = TW'(T_OFF - 1);
  localparam logic [BW-1:0] N_BW    = BW'(N_PISCA);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          led_q, led_d;
  logic          ocupado_q, ocupado_d;
  logic          pend_clr, pend_inc, pend_dec;
  logic [PW-1:0] pend_count;

  assign pend_clr = internal_reset || cancela;
  assign pend_inc = evento && (state_q != IDLE) && !pend_clr;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    blink_d  = blink_q;
    pend_dec = 1'b0;
    if (pend_clr) begin
      state_d = IDLE;
      timer_d = '0;
      blink_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (evento) begin
            state_d = ON;
            timer_d = '0;
            blink_d = BW'(1);
          end
        end
        ON: begin
          if (timer_q == FIM_ON) begin
            state_d = OFF;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        OFF: begin
          if (timer_q == FIM_OFF) begin
            timer_d = '0;
            if (blink_q < N_BW) begin
              blink_d = blink_q + 1'b1;
              state_d = ON;
            // An event in this very cycle is queued and consumed at once.
            end else if (pend_count != '0 || evento) begin
              pend_dec = 1'b1;
              blink_d  = BW'(1);
              state_d  = ON;
            end else begin
              blink_d = '0;
              state_d = IDLE;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          blink_d = '0;
        end
      endcase
    end
    led_d     = (state_d == ON);
    ocupado_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      blink_q   <= '0;
      led_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      blink_q   <= blink_d;
      led_q     <= led_d;
      ocupado_q <= ocupado_d;
    end
  end

  contador_pendentes #(
    .MAX (MAX_PEND),
    .W   (PW)
  ) u_pendentes (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pend_clr),
    .inc      (pend_inc),
    .dec      (pend_dec),
    .count    (pend_count),
    .overflow (overflow)
  );

  assign led       = led_q;
  assign ocupado   = ocupado_q;
  assign pendentes = pend_count;

endmodule

// File: tb/tb_sinalizador_led.sv
// Self-checking bench for sinalizador_led: scenario table plus a
// timeline-based reference model feeding a per-cycle scoreboard.
module tb_sinalizador_led;

  localparam int T_ON     = 3;
  localparam int T_OFF    = 2;
  localparam int N_PISCA  = 2;
  localparam int MAX_PEND = 3;
  localparam int P        = T_ON + T_OFF;
  localparam int L        = N_PISCA * P;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       internal_reset = 1'b0;
  logic       evento = 1'b0;
  logic       cancela = 1'b0;
  logic       led, ocupado, overflow;
  logic [1:0] pendentes;

  sinalizador_led #(
    .T_ON     (T_ON),
    .T_OFF    (T_OFF),
    .N_PISCA  (N_PISCA),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .internal_reset (internal_reset),
    .evento         (evento),
    .cancela        (cancela),
    .led            (led),
    .ocupado        (ocupado),
    .pendentes      (pendentes),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit led;
    bit ocu;
    int pend;
    bit ovf;
  } exp_t;

  typedef struct {
    string     nome;
    int        ncyc;
    bit [31:0] ev_m;
    bit [31:0] ca_m;
    bit [31:0] ir_m;
    int        chk_c;
    bit        e_led;
    bit        e_ocu;
    int        e_pend;
    bit        e_ovf;
  } cen_t;

  exp_t sb[$];
  cen_t cen[8];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: a burst is described by the cycle it started in.
  bit m_busy;
  int m_start;
  int m_pend;
  bit m_ovf;

  task automatic cmp(input string nm, input int c, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_start = 0;
    m_pend  = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input int c, input bit ev, input bit ca, input bit ir);
    int pin;
    m_ovf = 1'b0;
    if (ir || ca) begin
      m_busy = 1'b0;
      m_pend = 0;
    end else if (!m_busy) begin
      if (ev) begin
        m_busy  = 1'b1;
        m_start = c + 1;
      end
    end else begin
      pin = m_pend + (ev ? 1 : 0);
      if (c == m_start + L - 1) begin
        if (pin > 0) begin
          pin--;
          m_start = c + 1;
        end else begin
          m_busy = 1'b0;
        end
      end else if (pin > MAX_PEND) begin
        pin   = MAX_PEND;
        m_ovf = 1'b1;
      end
      m_pend = pin;
    end
  endtask

  task automatic run_cycle(input string nm, input int c, input bit ev, input bit ca, input bit ir);
    exp_t e;
    @(negedge clk);
    evento         = ev;
    cancela        = ca;
    internal_reset = ir;
    model_step(c, ev, ca, ir);
    e.ocu  = m_busy;
    e.led  = m_busy && (((c + 1 - m_start) % P) < T_ON);
    e.pend = m_pend;
    e.ovf  = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp({nm, ".led"},       c + 1, int'(led),       int'(e.led));
    cmp({nm, ".ocupado"},   c + 1, int'(ocupado),   int'(e.ocu));
    cmp({nm, ".pendentes"}, c + 1, int'(pendentes), e.pend);
    cmp({nm, ".overflow"},  c + 1, int'(overflow),  int'(e.ovf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    evento         = 1'b0;
    cancela        = 1'b0;
    internal_reset = 1'b0;
    #1;
    cmp("reset.led",       0, int'(led),       0);
    cmp("reset.ocupado",   0, int'(ocupado),   0);
    cmp("reset.pendentes", 0, int'(pendentes), 0);
    cmp("reset.overflow",  0, int'(overflow),  0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_cen(input int i);
    do_reset();
    for (int c = 0; c < cen[i].ncyc; c++) begin
      run_cycle(cen[i].nome, c, cen[i].ev_m[c], cen[i].ca_m[c], cen[i].ir_m[c]);
      if (c + 1 == cen[i].chk_c) begin
        cmp({cen[i].nome, ".spot.led"},       c + 1, int'(led),       int'(cen[i].e_led));
        cmp({cen[i].nome, ".spot.ocupado"},   c + 1, int'(ocupado),   int'(cen[i].e_ocu));
        cmp({cen[i].nome, ".spot.pendentes"}, c + 1, int'(pendentes), cen[i].e_pend);
        cmp({cen[i].nome, ".spot.overflow"},  c + 1, int'(overflow),  int'(cen[i].e_ovf));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cen[0] = '{"single",   14, 32'h1,                         '0,        '0,        11, 0, 0, 0, 0};
    cen[1] = '{"replay",   24, (1<<0)|(1<<4),                 '0,        '0,        11, 1, 1, 0, 0};
    cen[2] = '{"overflow", 10, (1<<0)|(1<<2)|(1<<3)|(1<<4)|(1<<5), '0,   '0,        6,  1, 1, 3, 1};
    cen[3] = '{"cancel",   12, (1<<0)|(1<<2),                 32'(1<<2), '0,        3,  0, 0, 0, 0};
    cen[4] = '{"int_rst",  22, (1<<0)|(1<<9),                 '0,        32'(1<<7), 8,  0, 0, 0, 0};
    cen[5] = '{"b2b",      24, (1<<0)|(1<<10),                '0,        '0,        11, 1, 1, 0, 0};
    cen[6] = '{"held",     32, (1<<0)|(1<<1)|(1<<2),          '0,        '0,        3,  1, 1, 2, 0};
    cen[7] = '{"full_end", 22, (1<<0)|(1<<1)|(1<<2)|(1<<3)|(1<<10), '0,  '0,        11, 1, 1, 3, 0};

    for (int i = 0; i < 8; i++) run_cen(i);

    // Asynchronous reset in the middle of a lit phase, then a fresh burst.
    do_reset();
    for (int c = 0; c < 7; c++) run_cycle("async", c, (c == 0), 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("async.led_now",       7, int'(led),       0);
    cmp("async.ocupado_now",   7, int'(ocupado),   0);
    cmp("async.pendentes_now", 7, int'(pendentes), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 13; c++) run_cycle("async_after", c, (c == 0), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
